// File: rtl/mulxbit_seq.sv
// mulxbit_seq: multi-cycle WIDTH x WIDTH multiplier with optional two's
// complement mode. Each RUN cycle retires BITS_PER_CYCLE multiplier bits.
// The core works on magnitudes. The sign is applied once, on the completion edge.
//
// Handshake (valid/ready style): start acts as "valid" and !busy as "ready".
// A request transfers on a rising edge where start=1 and busy=0. Operands
// and is_signed are captured on that edge and may change afterwards.
// done pulses for exactly one cycle, with out valid in that same cycle.
// out then holds its value until the next completion edge or a reset.
module mulxbit_seq #(
    parameter int WIDTH          = 24,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy,
    output logic                 done
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int PW = 2 * WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       state;
    // The multiplicand is kept pre-shifted. It moves left by BITS_PER_CYCLE
    // every RUN cycle, which equals shifting by count*BITS_PER_CYCLE without
    // needing a variable shifter.
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic             neg;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    result;
    logic             accept;

    // Operand magnitudes. -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1). That value
    // is still correct when read as unsigned.
    always_comb begin
        mag1 = in1;
        mag2 = in2;
        if (is_signed && in1[WIDTH-1]) mag1 = -in1;
        if (is_signed && in2[WIDTH-1]) mag2 = -in2;
    end

    // Partial product for the low digit of the multiplier, formed as a shift-and-add.
    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) pp = pp + (mcand << i);
        end
    end

    // Next accumulator value and the sign-corrected final product.
    always_comb begin
        acc_next = acc + pp;
        result   = neg ? -acc_next : acc_next;
    end

    // A new request is taken only while the unit is not busy.
    always_comb begin
        accept = start && ((state == S_IDLE) || (state == S_FINISH));
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            count  <= '0;
            out    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_FINISH: begin
                    if (accept) begin
                        mcand  <= PW'(mag1);
                        mplier <= mag2;
                        neg    <= is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        out   <= result;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FINISH;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mulxbit_seq.sv
// Bench for mulxbit_seq. A default 24x24 instance (N=6) runs directed vectors,
// a handshake sequence and a reset-mid-operation sequence. Three 8-bit
// instances (BITS_PER_CYCLE = 1, 2, 8) are compared against a reference
// multiply on random vectors.
module tb_mulxbit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [23:0] in1;
    logic [23:0] in2;
    logic [47:0] out;
    logic        busy;
    logic        done;

    logic        start8;
    logic        sg8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] out8 [3];
    logic [2:0]  busy8;
    logic [2:0]  done8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mulxbit_seq dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .in1(in1), .in2(in2), .out(out), .busy(busy), .done(done)
    );

    for (genvar g = 0; g < 3; g++) begin : g_w8
        mulxbit_seq #(.WIDTH(8), .BITS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 8))) u8 (
            .clk(clk), .rst(rst), .start(start8), .is_signed(sg8),
            .in1(a8), .in2(b8), .out(out8[g]), .busy(busy8[g]), .done(done8[g])
        );
    end

    typedef struct {
        logic        sg;
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] p;
        string       name;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One full operation on the 24-bit unit. It checks the latency, the product,
    // the busy window, and that done is a one-cycle pulse with out holding.
    // With mid_start=1, a start is pulsed while the unit is busy. That start must be ignored.
    task automatic run_op(input logic sg, input logic [23:0] a, input logic [23:0] b,
                          input logic [47:0] p, input string name, input bit mid_start);
        int lat     = -1;
        bit busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; is_signed = sg; in1 = a; in2 = b;
        @(posedge clk);
        for (int e = 0; e <= 12 && lat < 0; e++) begin
            @(negedge clk);
            if (e == 0) begin
                start     = 1'b0;
                in1       = 24'($urandom);
                in2       = 24'($urandom);
                is_signed = 1'($urandom_range(0, 1));
            end
            if (mid_start) start = (e == 2);
            if (done) lat = e;
            else if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(lat), 64'(6));
        check({name, "_out"}, 64'(out), 64'(p));
        check({name, "_busy_low_at_done"}, 64'(busy), 64'(0));
        check({name, "_busy_window"}, 64'(busy_ok), 64'(1));
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done), 64'(0));
        check({name, "_out_hold"}, 64'(out), 64'(p));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          j;
        int          last_done;
        int          cyc;
        bit          seen;
        int          lat8 [3];
        logic [15:0] got8 [3];
        int          exp_lat [3];
        logic [15:0] sa;
        logic [15:0] sb;
        logic [15:0] exp8;

        vecs[0] = '{1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "umax"};
        vecs[1] = '{1'b1, 24'hFFFFFD, 24'h000005, 48'hFFFFFFFFFFF1, "s_m3x5"};
        vecs[2] = '{1'b0, 24'hFFFFFD, 24'h000005, 48'h000004FFFFF1, "u_m3x5"};
        vecs[3] = '{1'b1, 24'h800000, 24'h800000, 48'h400000000000, "s_minxmin"};
        vecs[4] = '{1'b1, 24'h800000, 24'h000001, 48'hFFFFFF800000, "s_minx1"};
        vecs[5] = '{1'b1, 24'h000000, 24'hFFFFFF, 48'h000000000000, "s_zero_neg"};
        vecs[6] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'h000000000001, "s_m1xm1"};
        vecs[7] = '{1'b0, 24'h123456, 24'h000010, 48'h000001234560, "u_shift"};
        vecs[8] = '{1'b1, 24'h7FFFFF, 24'h7FFFFF, 48'h3FFFFF000001, "s_maxxmax"};
        vecs[9] = '{1'b1, 24'h7FFFFF, 24'h800000, 48'hC00000800000, "s_maxxmin"};

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; in1 = '0; in2 = '0;
        start8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_out", 64'(out), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_w8_busy", 64'(busy8), 64'(0));
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name, 1'b0);

        // A start pulsed mid-RUN must not disturb the operation or queue a second one.
        run_op(1'b1, 24'hFFFFFD, 24'h000005, 48'hFFFFFFFFFFF1, "mid_start", 1'b1);
        seen = 1'b0;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("mid_start_no_extra_done", 64'(seen), 64'(0));

        // Start held high, back to back. Each operand set is applied only on its accept edge.
        @(negedge clk);
        start = 1'b1; is_signed = vecs[0].sg; in1 = vecs[0].a; in2 = vecs[0].b;
        j = 0; last_done = -1; cyc = 0;
        while (j < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                check($sformatf("b2b_%0d_out", j), 64'(out), 64'(vecs[j].p));
                if (j > 0) check($sformatf("b2b_%0d_period", j), 64'(cyc - last_done), 64'(7));
                last_done = cyc;
                j++;
                if (j < 3) begin
                    is_signed = vecs[j].sg; in1 = vecs[j].a; in2 = vecs[j].b;
                end else begin
                    start = 1'b0;
                end
            end else begin
                is_signed = 1'($urandom_range(0, 1));
                in1 = 24'($urandom);
                in2 = 24'($urandom);
            end
        end
        start = 1'b0;
        check("b2b_count", 64'(j), 64'(3));

        // Reset asserted three cycles into RUN.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; in1 = 24'h000123; in2 = 24'h000456;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out", 64'(out), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("rst_mid_no_done", 64'(seen), 64'(0));
        run_op(1'b0, 24'h000123, 24'h000456, 48'h00000004EDC2, "after_rst", 1'b0);

        // WIDTH=8 sweep against a reference multiply.
        exp_lat[0] = 8; exp_lat[1] = 4; exp_lat[2] = 1;
        for (int v = 0; v < 1000; v++) begin
            @(negedge clk);
            if (v == 0) begin
                sg8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
            end else if (v == 1) begin
                sg8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
            end else if (v == 2) begin
                sg8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
            end else begin
                sg8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); b8 = 8'($urandom);
            end
            sa   = sg8 ? {{8{a8[7]}}, a8} : {8'h00, a8};
            sb   = sg8 ? {{8{b8[7]}}, b8} : {8'h00, b8};
            exp8 = sa * sb;
            start8 = 1'b1;
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                lat8[i] = -1;
                got8[i] = '0;
            end
            for (int e = 0; e < 12; e++) begin
                @(negedge clk);
                if (e == 0) begin
                    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
                end
                for (int i = 0; i < 3; i++) begin
                    if (done8[i] && lat8[i] < 0) begin
                        lat8[i] = e;
                        got8[i] = out8[i];
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                check($sformatf("w8_i%0d_v%0d_latency", i, v), 64'(lat8[i]), 64'(exp_lat[i]));
                check($sformatf("w8_i%0d_v%0d_out", i, v), 64'(got8[i]), 64'(exp8));
                check($sformatf("w8_i%0d_v%0d_busy", i, v), 64'(busy8[i]), 64'(0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mulxbit_seq.md
Name: mulxbit_seq

Overview:
- Parametrised, multi-cycle successor to the combinational fixed-point multiplier in the FPU mantissa datapath.
- Computes a full 2*WIDTH-bit product of two WIDTH-bit operands. Retires BITS_PER_CYCLE multiplier bits per clock, trading latency for area.
- Adds a signed (two's complement) mode and a start/busy/done handshake so the FPU control FSM can sequence it.

Parameters:
- WIDTH, 24, operand width in bits. Must be ≥ 2.
- BITS_PER_CYCLE, 4, multiplier bits consumed per RUN cycle. Must divide WIDTH.
- Derived, not overridable: N = WIDTH/BITS_PER_CYCLE = number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- is_signed  input  1  1 = operands and product are two's complement; 0 = unsigned. Sampled with start.
- in1  input  WIDTH  multiplicand; sampled with start
- in2  input  WIDTH  multiplier; sampled with start
- out  output  2*WIDTH  product register; holds its value until the next completion
- busy  output  1  high while an operation is in flight
- done  output  1  single-cycle completion pulse; out is valid in the same cycle

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state=IDLE.
  - out=0, busy=0, done=0.
  - Internal accumulator, count and operand registers are cleared.
- FSM states: IDLE, RUN, FINISH.
- IDLE or FINISH, start=1 (edge 0):
  - Latch mcand = |in1| and mplier = |in2|. Magnitudes are taken only if is_signed=1; otherwise the raw values are used.
  - Latch neg = is_signed & (in1[MSB] ^ in2[MSB]).
  - acc=0, count=0, busy=1, state=RUN.
- RUN, each edge:
  - acc += mcand * mplier[BITS_PER_CYCLE-1:0] << (count*BITS_PER_CYCLE). Accumulation is 2*WIDTH bits wide.
  - mplier >>= BITS_PER_CYCLE; count += 1.
  - When count == N-1 on this edge, go to FINISH.
- RUN to FINISH edge:
  - out = neg ? -(final acc) : final acc, modulo 2^(2*WIDTH).
  - done=1, busy=0.
- FINISH:
  - Lasts exactly one cycle.
  - If start=0, go to IDLE next edge; done drops to 0 and out holds.
  - If start=1, a new operation begins (back-to-back); done drops to 0.
- Latency: start sampled at edge 0, done=1 in the cycle after edge N. Default N=6, so throughput is one product per N+1 cycles with back-to-back starts.
- start while busy=1: ignored. No queueing, and operands in flight are unaffected.
- in1, in2, is_signed may change freely after the start edge.
- Most-negative operand (-2^(WIDTH-1)): its magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits, so no overflow. Product is exact in 2*WIDTH bits.
- Zero operand: the full N RUN cycles still elapse (no early termination). Result is 0, including when neg=1 (-0 = 0).
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse; the partial result is discarded.
- out changes only on the completion edge or on reset.

Test Plan:
- Unsigned max: is_signed=0, in1=in2=0xFFFFFF, pulse start → done exactly 6 cycles after the start edge, out=0xFFFFFE000001, busy high for cycles 1–6 after start then low.
- Signed mixed: is_signed=1, in1=0xFFFFFD (-3), in2=0x000005 → out=0xFFFFFFFFFFF1 (-15). Then same operands with is_signed=0 → out=0x000004FFFFF1.
- Signed extreme: is_signed=1, in1=in2=0x800000 → out=0x400000000000. Also in1=0x800000, in2=0x000001 → out=0xFFFFFF800000.
- Handshake: hold start=1 continuously with changing operands → starts accepted only at FINISH/IDLE, one done pulse every 7 cycles, each product matching the operands present at its accept edge. A start pulsed mid-RUN is ignored.
- Reset mid-op: assert rst 3 cycles into RUN → out=0, busy=0, done=0 immediately (asynchronous), and no done pulse follows. A new start after release gives a correct product.
- Parameter sweep: WIDTH=8 with BITS_PER_CYCLE=1, 2, 8 against 1000 random signed/unsigned vectors vs a reference model. done arrives 8, 4, 1 cycles after the start edge.
